column_drop_engine: RTL and testbench

- Parametrised gravity-drop engine for the Connect-4 board. Accepts "drop a piece in column c for player p" or "undo last move" requests over a valid/ready handshake.
- Tracks per-column fill height and validates each request. Emits one frame-buffer write per accepted move (address plus player code).
- Keeps a bounded undo history, plus column-full and board-full status.
- Sits between the game control FSM and the board RAM / VGA renderer.

---
 rtl/game_pkg.sv | 30 +++
 rtl/move_history_stack.sv | 50 +++++
 rtl/column_drop_engine.sv | 209 ++++++++++++++++++++
 tb/tb_column_drop_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the Connect-4 column drop engine: error codes,
// FSM encoding, the empty player code and port-width helpers.
package game_pkg;

    localparam logic [1:0] ERR_OK         = 2'd0;
    localparam logic [1:0] ERR_FULL       = 2'd1;
    localparam logic [1:0] ERR_BAD        = 2'd2;
    localparam logic [1:0] ERR_UNDO_EMPTY = 2'd3;

    localparam int EMPTY = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic int col_sel_w(input int cols, input int onehot);
        return (onehot != 0) ? cols : $clog2(cols);
    endfunction

    function automatic int addr_w(input int cols, input int rows);
        return $clog2(cols * rows);
    endfunction

    function automatic int count_w(input int cols, input int rows);
        return $clog2(cols * rows + 1);
    endfunction

endpackage

// File: rtl/move_history_stack.sv
// Circular LIFO of column indices used for undo; a push into a full stack
// silently overwrites the oldest entry so the newest DEPTH moves survive.
module move_history_stack #(
    parameter int DEPTH = 8,
    parameter int IW    = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [IW-1:0]                push_data,
    output logic [IW-1:0]                top,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int HCW  = $clog2(DEPTH + 1);

    logic [IW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wp;
    logic [HCW-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= push_data;
        end
    end

    // Write pointer wraps naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            cnt <= '0;
        end else if (push) begin
            wp <= wp + PTRW'(1);
            if (cnt != HCW'(DEPTH)) begin
                cnt <= cnt + HCW'(1);
            end
        end else if (pop) begin
            wp  <= wp - PTRW'(1);
            cnt <= cnt - HCW'(1);
        end
    end

    assign top   = mem[wp - PTRW'(1)];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/column_drop_engine.sv
// Gravity-drop engine: validates drop/undo requests, tracks column heights
// and emits one board-RAM write per successful move, two cycles after accept.
module column_drop_engine
    import game_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int PW         = 2,
    parameter int ONEHOT_IN  = 1,
    parameter int UNDO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_undo,
    input  logic [col_sel_w(COLS,ONEHOT_IN)-1:0] in_col,
    input  logic [PW-1:0]                        in_player,
    output logic                                 wr_valid,
    output logic [addr_w(COLS,ROWS)-1:0]         wr_addr,
    output logic [PW-1:0]                        wr_data,
    output logic                                 rsp_valid,
    output logic [1:0]                           rsp_err,
    output logic [COLS-1:0]                      col_full,
    output logic                                 board_full,
    output logic [count_w(COLS,ROWS)-1:0]        move_count
);

    localparam int CW   = col_sel_w(COLS, ONEHOT_IN);
    localparam int AW   = addr_w(COLS, ROWS);
    localparam int CNTW = count_w(COLS, ROWS);
    localparam int CIW  = $clog2(COLS);
    localparam int HW   = $clog2(ROWS + 1);
    localparam int RW   = $clog2(ROWS);
    localparam int HCW  = $clog2(UNDO_DEPTH + 1);

    state_t state, state_nxt;
    logic   accept;

    logic [HW-1:0] height [COLS];

    logic          undo_p0;
    logic [CW-1:0] col_p0;
    logic [PW-1:0] player_p0;

    logic           col_ok;
    logic [CIW-1:0] dec_col;
    logic [CIW-1:0] sel_col;
    logic [HW-1:0]  height_sel;
    logic [1:0]     chk_err;
    logic [RW-1:0]  chk_row;
    logic [AW-1:0]  cell_addr;

    logic [1:0]     err_p1;
    logic [CIW-1:0] col_p1;
    logic           undo_p1;

    logic            commit_ok;
    logic [HW-1:0]   height_upd;
    logic [COLS-1:0] col_full_nxt;

    logic           hist_push;
    logic           hist_pop;
    logic [CIW-1:0] hist_top;
    logic           hist_empty;
    logic [HCW-1:0] hist_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK:  state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Stage p0: request captured at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            undo_p0   <= in_undo;
            col_p0    <= in_col;
            player_p0 <= in_player;
        end
    end

    generate
        if (ONEHOT_IN != 0) begin : g_onehot
            always_comb begin
                dec_col = '0;
                for (int i = 0; i < COLS; i++) begin
                    if (col_p0[i]) begin
                        dec_col = CIW'(i);
                    end
                end
            end
            assign col_ok = $onehot(col_p0);
        end else begin : g_binary
            assign dec_col = col_p0;
            assign col_ok  = ({1'b0, col_p0} < (CW+1)'(COLS));
        end
    endgenerate

    // Undo takes its column from the history; a drop uses the decoded input.
    always_comb begin
        sel_col    = undo_p0 ? hist_top : dec_col;
        height_sel = height[sel_col];
        chk_err    = ERR_OK;
        if (undo_p0) begin
            if (hist_empty) begin
                chk_err = ERR_UNDO_EMPTY;
            end
            chk_row = RW'(HW'(ROWS) - height_sel);
        end else begin
            if (!col_ok || player_p0 == PW'(EMPTY)) begin
                chk_err = ERR_BAD;
            end else if (height_sel == HW'(ROWS)) begin
                chk_err = ERR_FULL;
            end
            chk_row = RW'(HW'(ROWS - 1) - height_sel);
        end
        cell_addr = AW'(chk_row) * AW'(COLS) + AW'(sel_col);
    end

    // Stage p1: CHECK verdict held for the COMMIT state update
    always_ff @(posedge clk) begin
        if (state == ST_CHECK) begin
            err_p1  <= chk_err;
            col_p1  <= sel_col;
            undo_p1 <= undo_p0;
        end
    end

    assign commit_ok  = (state == ST_COMMIT) && (err_p1 == ERR_OK);
    assign height_upd = undo_p1 ? (height[col_p1] - HW'(1)) : (height[col_p1] + HW'(1));
    assign hist_push  = commit_ok && !undo_p1;
    assign hist_pop   = commit_ok && undo_p1 && (hist_count != '0);

    always_comb begin
        col_full_nxt         = col_full;
        col_full_nxt[col_p1] = (height_upd == HW'(ROWS));
    end

    // Stage p2: response/write strobes for COMMIT, state update leaving it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= ERR_OK;
            col_full   <= '0;
            board_full <= 1'b0;
            move_count <= '0;
            for (int c = 0; c < COLS; c++) begin
                height[c] <= '0;
            end
        end else begin
            wr_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            if (state == ST_CHECK) begin
                rsp_valid <= 1'b1;
                rsp_err   <= chk_err;
                if (chk_err == ERR_OK) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= cell_addr;
                    wr_data  <= undo_p0 ? PW'(EMPTY) : player_p0;
                end
            end
            if (commit_ok) begin
                height[col_p1] <= height_upd;
                col_full       <= col_full_nxt;
                board_full     <= &col_full_nxt;
                move_count     <= undo_p1 ? (move_count - CNTW'(1)) : (move_count + CNTW'(1));
            end
        end
    end

    move_history_stack #(
        .DEPTH (UNDO_DEPTH),
        .IW    (CIW)
    ) u_history (
        .clk       (clk),
        .reset     (reset),
        .push      (hist_push),
        .pop       (hist_pop),
        .push_data (col_p1),
        .top       (hist_top),
        .empty     (hist_empty),
        .count     (hist_count)
    );

endmodule

// File: tb/tb_column_drop_engine.sv
// Directed bench for column_drop_engine: a reference model predicts each
// response into a scoreboard queue, popped and checked at the COMMIT cycle.
module tb_column_drop_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, in_undo;
    logic [7:0] in_col;
    logic [1:0] in_player;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [7:0] col_full;
    logic       board_full;
    logic [6:0] move_count;

    logic       b_in_valid, b_in_ready;
    logic [2:0] b_in_col;
    logic [1:0] b_in_player;
    logic       b_wr_valid;
    logic [5:0] b_wr_addr;
    logic [1:0] b_wr_data;
    logic       b_rsp_valid;
    logic [1:0] b_rsp_err;
    logic [6:0] b_col_full;
    logic       b_board_full;
    logic [5:0] b_move_count;

    column_drop_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_undo(in_undo), .in_col(in_col), .in_player(in_player),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .col_full(col_full),
        .board_full(board_full), .move_count(move_count)
    );

    column_drop_engine #(.COLS(7), .ROWS(8), .PW(2), .ONEHOT_IN(0), .UNDO_DEPTH(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_undo(1'b0), .in_col(b_in_col), .in_player(b_in_player),
        .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .col_full(b_col_full),
        .board_full(b_board_full), .move_count(b_move_count)
    );

    typedef struct {
        int err;
        int wr;
        int addr;
        int data;
    } exp_t;

    exp_t sb[$];
    int   ht[8];
    int   hist[$];
    int   mc;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ht[i] = 0;
        hist.delete();
        sb.delete();
        mc = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_req(input bit undo, input logic [7:0] col, input logic [1:0] pl);
        exp_t e;
        int   c;
        int   waited;
        e.err = 0; e.wr = 0; e.addr = 0; e.data = 0;
        if (undo) begin
            if (hist.size() == 0) begin
                e.err = 3;
            end else begin
                c = hist.pop_back();
                e.addr = (8 - ht[c]) * 8 + c;
                ht[c]--;
                mc--;
                e.wr = 1;
            end
        end else if ($countones(col) != 1 || pl == 2'd0) begin
            e.err = 2;
        end else begin
            c = 0;
            for (int i = 0; i < 8; i++) if (col[i]) c = i;
            if (ht[c] == 8) begin
                e.err = 1;
            end else begin
                e.addr = (7 - ht[c]) * 8 + c;
                e.data = pl;
                e.wr = 1;
                ht[c]++;
                mc++;
                if (hist.size() == 8) void'(hist.pop_front());
                hist.push_back(c);
            end
        end
        sb.push_back(e);

        waited = 0;
        while (!in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready", in_ready, 1);
        in_valid = 1'b1; in_undo = undo; in_col = col; in_player = pl;
        @(negedge clk);
        in_valid = 1'b0; in_undo = 1'b0; in_col = '0; in_player = '0;
        chk("rsp_valid_in_check", rsp_valid, 0);
        @(negedge clk);
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, e.err);
        chk("wr_valid", wr_valid, e.wr);
        if (e.wr != 0) begin
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
        end
        @(negedge clk);
        chk("move_count_model", move_count, mc);
    endtask

    task automatic do_req_b(input logic [2:0] col, input logic [1:0] pl,
                            input int exp_err, input int exp_wr, input int exp_addr);
        b_in_valid = 1'b1; b_in_col = col; b_in_player = pl;
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_rsp_valid", b_rsp_valid, 1);
        chk("b_rsp_err", b_rsp_err, exp_err);
        chk("b_wr_valid", b_wr_valid, exp_wr);
        if (exp_wr != 0) chk("b_wr_addr", b_wr_addr, exp_addr);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_undo = 1'b0; in_col = '0; in_player = '0;
        b_in_valid = 1'b0; b_in_col = '0; b_in_player = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_col_full", col_full, 0);
        chk("rst_board_full", board_full, 0);
        chk("rst_move_count", move_count, 0);

        // Basic drops in column 0: addresses 56 then 48
        do_req(1'b0, 8'h01, 2'd1);
        chk("first_drop_addr", wr_addr, 56);
        do_req(1'b0, 8'h01, 2'd2);
        chk("second_drop_addr", wr_addr, 48);

        // Fill column 3, then overflow
        apply_reset();
        for (int i = 0; i < 8; i++) do_req(1'b0, 8'h08, 2'((i % 2) + 1));
        do_req(1'b0, 8'h08, 2'd1);
        chk("col3_full", col_full, 8'h08);
        chk("col3_count", move_count, 8);

        // Bad requests leave state untouched
        do_req(1'b0, 8'h05, 2'd1);
        do_req(1'b0, 8'h02, 2'd0);
        do_req(1'b0, 8'h00, 2'd3);
        chk("bad_count", move_count, 8);
        chk("bad_col_full", col_full, 8'h08);

        // Drops 2,5,5 then undos
        apply_reset();
        do_req(1'b0, 8'h04, 2'd1);
        do_req(1'b0, 8'h20, 2'd2);
        do_req(1'b0, 8'h20, 2'd1);
        do_req(1'b1, 8'h00, 2'd0);
        chk("undo1_addr", wr_addr, 53);
        do_req(1'b1, 8'h00, 2'd0);
        chk("undo2_addr", wr_addr, 61);
        do_req(1'b1, 8'h00, 2'd0);
        chk("undo3_addr", wr_addr, 58);
        do_req(1'b1, 8'h00, 2'd0);
        chk("undo4_err", rsp_err, 3);

        // History depth: 10 drops, 9 undos
        apply_reset();
        for (int i = 0; i < 10; i++) do_req(1'b0, 8'(1 << (i % 8)), 2'd1);
        for (int i = 0; i < 9; i++) do_req(1'b1, 8'h00, 2'd0);
        chk("depth_last_err", rsp_err, 3);
        chk("depth_count", move_count, 2);

        // Fill the board
        apply_reset();
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                do_req(1'b0, 8'(1 << c), 2'((r % 2) + 1));
        chk("full_board_full", board_full, 1);
        chk("full_move_count", move_count, 64);
        chk("full_col_full", col_full, 8'hff);
        do_req(1'b0, 8'h10, 2'd2);

        // Reset asserted in the CHECK cycle aborts the request
        @(negedge clk);
        in_valid = 1'b1; in_undo = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_undo = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_wr_valid", wr_valid, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_board_full", board_full, 0);
        chk("abort_move_count", move_count, 0);
        chk("abort_col_full", col_full, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
            chk("abort_no_wr", wr_valid, 0);
        end

        // Binary-coded 7-column instance
        do_req_b(3'd7, 2'd1, 2, 0, 0);
        do_req_b(3'd6, 2'd1, 0, 1, 55);
        do_req_b(3'd6, 2'd2, 0, 1, 48);
        chk("b_move_count", b_move_count, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
